puf_chal_sequencer: RTL and testbench
=====================================

// Module: puf_chal_sequencer
// PURPOSE
//  Sequences the arbiter-PUF datapath: sweeps a challenge range and runs REPS reset/enable/trigger
//  cycles per challenge. Collects one response bit per repetition and majority-votes them.
//  Hands {challenge, votes, majority, unstable} to the UART framer over a valid/ready interface.
//  Sits between the top-level run control and the PUF core, replacing hand-coded FSM in the top.
// PARAMETERS
//  CW          16  challenge width (bits)
//  REPS        7   repetitions per challenge; odd, 3..15
//  LOAD_CYC    2   cycles puf_rst held high with challenge driven (>=2)
//  SETTLE_CYC  16  cycles puf_en high before trigger (>=2)
// PORTS
//  clk          in   1     system clock
//  rst_n        in   1     asynchronous active-low reset
//  start        in   1     begin sweep; sampled in IDLE/DONE only
//  abort        in   1     synchronous abort to IDLE from any state
//  chal_first   in   CW    first challenge, latched on accepted start
//  chal_last    in   CW    last challenge, latched on accepted start
//  puf_rst      out  1     PUF reset, active high
//  puf_en       out  1     PUF enable / stage CE
//  puf_ten      out  1     PUF trigger enable
//  puf_chal     out  CW    challenge to PUF
//  puf_resp     in   1     PUF response; stable by the cycle after puf_ten
//  out_valid    out  1     result available
//  out_ready    in   1     framer accepts result
//  out_chal     out  CW    challenge of current result
//  out_votes    out  REPS  raw responses; bit r = repetition r
//  out_maj      out  1     majority of out_votes
//  out_unstable out  1     out_votes not all equal
//  unstable_cnt out  16    count of unstable challenges this sweep; saturates at 16'hFFFF
//  busy         out  1     state not IDLE/DONE
//  done         out  1     high in DONE
// BEHAVIOUR
//  Reset: state=IDLE. puf_rst=1. All other outputs, counters, and registers = 0.
//  States and transitions (all outputs registered):
//   IDLE   : start -> LOAD. Latch chal_first/chal_last, cur=chal_first, rep=0, unstable_cnt=0.
//   LOAD   : puf_rst=1, puf_chal=cur. After LOAD_CYC cycles -> ARM.
//   ARM    : puf_rst=0, puf_en=0. After 2 cycles -> SETTLE.
//   SETTLE : puf_en=1. After SETTLE_CYC cycles -> TRIG.
//   TRIG   : puf_en=1, puf_ten=1 for exactly 1 cycle -> SAMPLE.
//   SAMPLE : puf_en=0. votes[rep]<=puf_resp.
//            If rep==REPS-1 -> EMIT; otherwise rep++ -> LOAD.
//   EMIT   : out_valid=1. Payload is stable while valid. On valid&&ready -> NEXT.
//            unstable_cnt++ (saturating) at handshake when out_unstable=1.
//   NEXT   : cur==chal_last -> DONE; otherwise cur<=cur+1 (mod 2^CW), rep=0, votes=0 -> LOAD.
//   DONE   : done=1, puf_rst=1. start -> as from IDLE (new sweep).
//  Per-repetition latency = LOAD_CYC+2+SETTLE_CYC+2 cycles (defaults: 22). out_valid asserts 1 cycle after last SAMPLE.
//  out_maj = popcount(votes) > REPS/2. out_unstable = |votes & ~&votes.
//  chal_first==chal_last -> exactly one result. chal_last<chal_first -> wraps through 2^CW-1 to 0.
//  start ignored while busy. out_ready ignored outside EMIT.
//  abort has priority over every transition, including the EMIT handshake cycle:
//   next cycle state=IDLE, puf_rst=1, puf_en=puf_ten=out_valid=0, no count update.
//  Async reset mid-sweep: immediate return to reset values.
// STRUCTURE
//  puf_ctrl_defs.vh: state encodings (Gray, IDLE=0), ARM_CYC=2, UNST_W=16.
//  Sub-module puf_vote_tally (REPS): combinational popcount -> maj, unstable.
//  Single cycle counter shared by LOAD/ARM/SETTLE, width $clog2(max(LOAD_CYC,SETTLE_CYC)+1).
// TESTING
//  1 Defaults, first=last=16'h0005, puf_resp=1 -> one result: chal 0005, votes 7'h7F, maj=1, unstable=0, done.
//  2 puf_resp pattern 1,0,1,1,0,0,1 -> votes 7'b1001101, maj=1, unstable=1, unstable_cnt=1.
//  3 first=16'hFFFE, last=16'h0001 -> results FFFE, FFFF, 0000, 0001 in order, then done.
//  4 out_ready low 50 cycles in EMIT -> out_valid held, payload stable, no PUF activity, accept once.
//  5 abort during SETTLE of rep 3 -> next cycle IDLE, puf_rst=1, puf_en=0; new start restarts at chal_first.
//  6 Check timing: puf_ten pulse 1 cycle, preceded by exactly 16 puf_en cycles; rep period 22 cycles.

Source files
------------

// File: rtl/puf_chal_sequencer_pkg.sv
// Shared definitions for the arbiter-PUF challenge sequencer.
// State codes are Gray-ordered along the normal flow, with IDLE at zero.
package puf_chal_sequencer_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'b0000,
        S_LOAD   = 4'b0001,
        S_ARM    = 4'b0011,
        S_SETTLE = 4'b0010,
        S_TRIG   = 4'b0110,
        S_SAMPLE = 4'b0111,
        S_EMIT   = 4'b0101,
        S_NEXT   = 4'b0100,
        S_DONE   = 4'b1100
    } state_t;

    localparam int unsigned ARM_CYC = 2;
    localparam int unsigned UNST_W  = 16;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/puf_chal_sequencer_vote_tally.sv
// Combinational majority vote over the per-repetition PUF responses.
module puf_vote_tally
    import puf_chal_sequencer_pkg::*;
#(
    parameter int unsigned REPS = 7
) (
    input  logic [REPS-1:0] votes,
    output logic            maj,
    output logic            unstable
);

    localparam int unsigned PC_W = $clog2(REPS + 1);

    logic [PC_W-1:0] ones;

    always_comb begin
        ones = '0;
        for (int unsigned i = 0; i < REPS; i++) begin
            ones = ones + PC_W'(votes[i]);
        end
    end

    assign maj      = ones > PC_W'(REPS / 2);
    assign unstable = (|votes) & ~(&votes);

endmodule

// File: rtl/puf_chal_sequencer.sv
// Sweeps a challenge range through the arbiter PUF, repeating each challenge REPS times,
// and hands the majority-voted result to the framer over valid/ready.
module puf_chal_sequencer
    import puf_chal_sequencer_pkg::*;
#(
    parameter int unsigned CW         = 16,
    parameter int unsigned REPS       = 7,
    parameter int unsigned LOAD_CYC   = 2,
    parameter int unsigned SETTLE_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CW-1:0]     chal_first,
    input  logic [CW-1:0]     chal_last,
    output logic              puf_rst,
    output logic              puf_en,
    output logic              puf_ten,
    output logic [CW-1:0]     puf_chal,
    input  logic              puf_resp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW-1:0]     out_chal,
    output logic [REPS-1:0]   out_votes,
    output logic              out_maj,
    output logic              out_unstable,
    output logic [UNST_W-1:0] unstable_cnt,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = $clog2(max2(LOAD_CYC, SETTLE_CYC) + 1);
    localparam int unsigned REP_W = $clog2(REPS);

    state_t          state;
    logic [CNT_W-1:0] cnt;
    logic [REP_W-1:0] rep;
    logic [CW-1:0]    cur;
    logic [CW-1:0]    last_q;
    logic [REPS-1:0]  votes;
    logic [REPS-1:0]  votes_nxt;
    logic             maj_nxt;
    logic             unst_nxt;

    // Tally the vote vector including the bit being sampled this cycle, so the
    // verdict can be registered on the same edge that enters EMIT.
    always_comb begin
        votes_nxt      = votes;
        votes_nxt[rep] = puf_resp;
    end

    puf_vote_tally #(.REPS(REPS)) u_tally (
        .votes    (votes_nxt),
        .maj      (maj_nxt),
        .unstable (unst_nxt)
    );

    assign out_chal  = cur;
    assign out_votes = votes;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            rep          <= '0;
            cur          <= '0;
            last_q       <= '0;
            votes        <= '0;
            puf_rst      <= 1'b1;
            puf_en       <= 1'b0;
            puf_ten      <= 1'b0;
            puf_chal     <= '0;
            out_valid    <= 1'b0;
            out_maj      <= 1'b0;
            out_unstable <= 1'b0;
            unstable_cnt <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else if (abort) begin
            state     <= S_IDLE;
            cnt       <= '0;
            puf_rst   <= 1'b1;
            puf_en    <= 1'b0;
            puf_ten   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        last_q       <= chal_last;
                        cur          <= chal_first;
                        puf_chal     <= chal_first;
                        rep          <= '0;
                        votes        <= '0;
                        cnt          <= '0;
                        out_maj      <= 1'b0;
                        out_unstable <= 1'b0;
                        unstable_cnt <= '0;
                        puf_rst      <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        state        <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (cnt == CNT_W'(LOAD_CYC - 1)) begin
                        cnt     <= '0;
                        puf_rst <= 1'b0;
                        state   <= S_ARM;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_ARM: begin
                    if (cnt == CNT_W'(ARM_CYC - 1)) begin
                        cnt    <= '0;
                        puf_en <= 1'b1;
                        state  <= S_SETTLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
                        cnt     <= '0;
                        puf_ten <= 1'b1;
                        state   <= S_TRIG;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_TRIG: begin
                    puf_ten <= 1'b0;
                    puf_en  <= 1'b0;
                    state   <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    votes <= votes_nxt;
                    if (rep == REP_W'(REPS - 1)) begin
                        out_maj      <= maj_nxt;
                        out_unstable <= unst_nxt;
                        out_valid    <= 1'b1;
                        state        <= S_EMIT;
                    end else begin
                        rep     <= rep + 1'b1;
                        puf_rst <= 1'b1;
                        state   <= S_LOAD;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_unstable && (unstable_cnt != '1)) begin
                            unstable_cnt <= unstable_cnt + 1'b1;
                        end
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    puf_rst <= 1'b1;
                    if (cur == last_q) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        cur          <= cur + 1'b1;
                        puf_chal     <= cur + 1'b1;
                        rep          <= '0;
                        votes        <= '0;
                        out_maj      <= 1'b0;
                        out_unstable <= 1'b0;
                        state        <= S_LOAD;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    puf_rst   <= 1'b1;
                    puf_en    <= 1'b0;
                    puf_ten   <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_chal_sequencer.sv
// Directed bench for puf_chal_sequencer: single-challenge vector table plus
// wrap, back-pressure, abort, timing and async-reset sequences.
module tb_puf_chal_sequencer;
    import puf_chal_sequencer_pkg::*;

    localparam int unsigned CW   = 16;
    localparam int unsigned REPS = 7;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [CW-1:0]     chal_first = '0;
    logic [CW-1:0]     chal_last = '0;
    logic              puf_rst;
    logic              puf_en;
    logic              puf_ten;
    logic [CW-1:0]     puf_chal;
    logic              puf_resp = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CW-1:0]     out_chal;
    logic [REPS-1:0]   out_votes;
    logic              out_maj;
    logic              out_unstable;
    logic [UNST_W-1:0] unstable_cnt;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    puf_chal_sequencer #(
        .CW         (CW),
        .REPS       (REPS),
        .LOAD_CYC   (2),
        .SETTLE_CYC (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .chal_first   (chal_first),
        .chal_last    (chal_last),
        .puf_rst      (puf_rst),
        .puf_en       (puf_en),
        .puf_ten      (puf_ten),
        .puf_chal     (puf_chal),
        .puf_resp     (puf_resp),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_chal     (out_chal),
        .out_votes    (out_votes),
        .out_maj      (out_maj),
        .out_unstable (out_unstable),
        .unstable_cnt (unstable_cnt),
        .busy         (busy),
        .done         (done)
    );

    int              vectors = 0;
    int              errors  = 0;
    int unsigned     ten_cnt  = 0;
    int unsigned     ten_base = 0;
    logic [REPS-1:0] pat = '0;

    // PUF model: response for repetition r is pat[r], presented during the trigger cycle.
    always @(negedge clk) begin
        if (puf_ten) begin
            int unsigned idx;
            idx = (ten_cnt - ten_base) % REPS;
            puf_resp = pat[idx[2:0]];
            ten_cnt++;
        end
    end

    typedef struct {
        logic [CW-1:0]   chal;
        logic [REPS-1:0] pat;
        logic [REPS-1:0] votes;
        logic            maj;
        logic            unst;
        logic [15:0]     cnt;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_start(input logic [CW-1:0] f, input logic [CW-1:0] l, input logic [REPS-1:0] p);
        pat        = p;
        ten_base   = ten_cnt;
        chal_first = f;
        chal_last  = l;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("out_valid_wait", 32'(ok), 32'd1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [CW-1:0]   wrap_exp [4];
        logic [CW-1:0]   hold_chal;
        logic [REPS-1:0] hold_votes;
        bit              bad_valid, bad_payload, bad_puf, found, width_bad, seen_valid;
        int              en_run, last_ten, nten;
        bit              prev_ten;

        tbl[0] = '{chal: 16'h0005, pat: 7'h7F,       votes: 7'h7F,       maj: 1'b1, unst: 1'b0, cnt: 16'd0};
        tbl[1] = '{chal: 16'h1234, pat: 7'b1001101,  votes: 7'b1001101,  maj: 1'b1, unst: 1'b1, cnt: 16'd1};
        tbl[2] = '{chal: 16'hABCD, pat: 7'b0000000,  votes: 7'b0000000,  maj: 1'b0, unst: 1'b0, cnt: 16'd0};
        tbl[3] = '{chal: 16'hFFFF, pat: 7'b0001110,  votes: 7'b0001110,  maj: 1'b0, unst: 1'b1, cnt: 16'd1};
        tbl[4] = '{chal: 16'h0000, pat: 7'b1111000,  votes: 7'b1111000,  maj: 1'b1, unst: 1'b1, cnt: 16'd1};

        wrap_exp[0] = 16'hFFFE;
        wrap_exp[1] = 16'hFFFF;
        wrap_exp[2] = 16'h0000;
        wrap_exp[3] = 16'h0001;

        // Reset values
        repeat (3) tick();
        chk("rst_puf_rst", 32'(puf_rst), 32'd1);
        chk("rst_puf_en", 32'(puf_en), 32'd0);
        chk("rst_puf_ten", 32'(puf_ten), 32'd0);
        chk("rst_puf_chal", 32'(puf_chal), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_unstable_cnt", 32'(unstable_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // Single-challenge sweeps
        for (int v = 0; v < 5; v++) begin
            do_start(tbl[v].chal, tbl[v].chal, tbl[v].pat);
            chk("start_puf_chal", 32'(puf_chal), 32'(tbl[v].chal));
            chk("start_busy", 32'(busy), 32'd1);
            wait_valid(400);
            chk("tbl_chal", 32'(out_chal), 32'(tbl[v].chal));
            chk("tbl_votes", 32'(out_votes), 32'(tbl[v].votes));
            chk("tbl_maj", 32'(out_maj), 32'(tbl[v].maj));
            chk("tbl_unstable", 32'(out_unstable), 32'(tbl[v].unst));
            handshake();
            chk("tbl_unstable_cnt", 32'(unstable_cnt), 32'(tbl[v].cnt));
            chk("tbl_valid_drop", 32'(out_valid), 32'd0);
            tick();
            chk("tbl_done", 32'(done), 32'd1);
            chk("tbl_busy_done", 32'(busy), 32'd0);
            chk("tbl_puf_rst_done", 32'(puf_rst), 32'd1);
        end

        // Wrap through 2^CW-1 to 0
        do_start(16'hFFFE, 16'h0001, 7'b1001101);
        for (int k = 0; k < 4; k++) begin
            wait_valid(400);
            chk("wrap_chal", 32'(out_chal), 32'(wrap_exp[k]));
            chk("wrap_votes", 32'(out_votes), 32'h4D);
            handshake();
        end
        tick();
        chk("wrap_done", 32'(done), 32'd1);
        chk("wrap_unstable_cnt", 32'(unstable_cnt), 32'd4);

        // Back-pressure: hold out_ready low for 50 cycles in EMIT
        do_start(16'h0042, 16'h0042, 7'h7F);
        wait_valid(400);
        hold_chal   = out_chal;
        hold_votes  = out_votes;
        bad_valid   = 1'b0;
        bad_payload = 1'b0;
        bad_puf     = 1'b0;
        repeat (50) begin
            tick();
            if (!out_valid) bad_valid = 1'b1;
            if (out_chal !== hold_chal || out_votes !== hold_votes || out_maj !== 1'b1) bad_payload = 1'b1;
            if (puf_en || puf_ten || puf_rst) bad_puf = 1'b1;
        end
        chk("bp_chal", 32'(hold_chal), 32'h0042);
        chk("bp_valid_held", 32'(bad_valid), 32'd0);
        chk("bp_payload_stable", 32'(bad_payload), 32'd0);
        chk("bp_no_puf_activity", 32'(bad_puf), 32'd0);
        handshake();
        chk("bp_valid_drop", 32'(out_valid), 32'd0);
        tick();
        chk("bp_done", 32'(done), 32'd1);
        repeat (5) tick();
        chk("bp_accept_once", 32'(out_valid), 32'd0);

        // Abort during SETTLE of repetition 3
        do_start(16'h0010, 16'h0012, 7'h7F);
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ((ten_cnt - ten_base) == 3 && puf_en && !puf_ten) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("abort_reach_settle", 32'(found), 32'd1);
        repeat (5) tick();
        chk("abort_in_settle", 32'(puf_en), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_puf_rst", 32'(puf_rst), 32'd1);
        chk("abort_puf_en", 32'(puf_en), 32'd0);
        chk("abort_puf_ten", 32'(puf_ten), 32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (3) tick();
        chk("abort_stays_idle", 32'(busy), 32'd0);
        do_start(16'h0020, 16'h0020, 7'h7F);
        chk("restart_puf_chal", 32'(puf_chal), 32'h0020);
        wait_valid(400);
        chk("restart_chal", 32'(out_chal), 32'h0020);
        chk("restart_votes", 32'(out_votes), 32'h7F);
        handshake();
        tick();
        chk("restart_done", 32'(done), 32'd1);

        // Abort on the EMIT handshake cycle: no count update, back to IDLE
        do_start(16'h0030, 16'h0030, 7'b1001101);
        wait_valid(400);
        abort     = 1'b1;
        out_ready = 1'b1;
        tick();
        abort     = 1'b0;
        out_ready = 1'b0;
        chk("abort_hs_valid", 32'(out_valid), 32'd0);
        chk("abort_hs_cnt", 32'(unstable_cnt), 32'd0);
        chk("abort_hs_busy", 32'(busy), 32'd0);
        chk("abort_hs_done", 32'(done), 32'd0);

        // Timing: trigger pulse width, settle length, repetition period, output latency
        do_start(16'h0007, 16'h0007, 7'h7F);
        en_run     = 0;
        last_ten   = -1;
        nten       = 0;
        prev_ten   = 1'b0;
        width_bad  = 1'b0;
        seen_valid = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (out_valid) begin
                seen_valid = 1'b1;
                chk("valid_latency", 32'(cyc - last_ten), 32'd2);
                break;
            end
            if (puf_ten) begin
                if (prev_ten) width_bad = 1'b1;
                chk("ten_with_en", 32'(puf_en), 32'd1);
                chk("settle_len", 32'(en_run), 32'd16);
                if (last_ten >= 0) chk("rep_period", 32'(cyc - last_ten), 32'd22);
                last_ten = cyc;
                nten++;
            end
            en_run   = (puf_en && !puf_ten) ? en_run + 1 : 0;
            prev_ten = puf_ten;
            tick();
        end
        chk("timing_valid_seen", 32'(seen_valid), 32'd1);
        chk("ten_pulses", 32'(nten), 32'd7);
        chk("ten_width_one", 32'(width_bad), 32'd0);
        handshake();
        tick();
        chk("timing_done", 32'(done), 32'd1);

        // Asynchronous reset mid-sweep
        do_start(16'h0050, 16'h0060, 7'h7F);
        repeat (30) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_puf_rst", 32'(puf_rst), 32'd1);
        chk("arst_puf_en", 32'(puf_en), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_puf_chal", 32'(puf_chal), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_idle_busy", 32'(busy), 32'd0);
        chk("arst_out_chal", 32'(out_chal), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
